// File: rtl/uart_rx_ctrl_pkg.sv
// Shared UART definitions: receive/transmit FSM state encodings and legal prescale ratios.
package uart_rx_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_CHECK  = 3'd5
  } uart_state_t;

  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

endpackage

// File: rtl/uart_rx_sampler.sv
// Triple-samples rx_in around the bit centre and registers the 2-of-3 majority.
module uart_rx_sampler #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  sample_bit
);

  logic [PRESCALE_W-1:0] half;
  logic                  s0_reg;
  logic                  s1_reg;

  assign half = prescale >> 1;

  // The third sample is folded straight into the vote, so the result is
  // ready from edge half+2 onward.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0_reg     <= 1'b0;
      s1_reg     <= 1'b0;
      sample_bit <= 1'b0;
    end else begin
      if (edge_cnt == half - PRESCALE_W'(1)) s0_reg <= rx_in;
      if (edge_cnt == half)                  s1_reg <= rx_in;
      if (edge_cnt == half + PRESCALE_W'(1))
        sample_bit <= (s0_reg & s1_reg) | (s0_reg & rx_in) | (s1_reg & rx_in);
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start detect, oversampled majority-vote deserialiser,
// parity/stop checking and a one-cycle valid pulse towards the system controller.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  uart_state_t           state_reg, state_next;
  logic [PRESCALE_W-1:0] edge_cnt_reg;
  logic [PRESCALE_W-1:0] presc_reg;
  logic [BCW-1:0]        bit_cnt_reg;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  perr_flag_reg;
  logic                  maj_bit;
  logic                  edge_last;
  logic                  par_mismatch;

  uart_rx_sampler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_sampler (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .edge_cnt  (edge_cnt_reg),
    .prescale  (presc_reg),
    .sample_bit(maj_bit)
  );

  assign edge_last    = (edge_cnt_reg == presc_reg - PRESCALE_W'(1));
  assign par_mismatch = maj_bit != ((^shift_reg) ^ par_typ);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (!rx_in) state_next = ST_START;
      ST_START:  if (edge_last) state_next = maj_bit ? ST_IDLE : ST_DATA;
      ST_DATA:
        if (edge_last && (bit_cnt_reg == BCW'(DATA_WIDTH - 1)))
          state_next = par_en ? ST_PARITY : ST_STOP;
      ST_PARITY: if (edge_last) state_next = ST_STOP;
      ST_STOP:   if (edge_last) state_next = ST_CHECK;
      ST_CHECK:  state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      edge_cnt_reg  <= '0;
      presc_reg     <= PRESCALE_W'(PRESCALE_8);
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      perr_flag_reg <= 1'b0;
      p_data        <= '0;
      data_valid    <= 1'b0;
      par_err       <= 1'b0;
      stp_err       <= 1'b0;
    end else begin
      state_reg  <= state_next;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          // The detect cycle is edge 0, so the first START cycle is edge 1.
          edge_cnt_reg  <= rx_in ? '0 : PRESCALE_W'(1);
          bit_cnt_reg   <= '0;
          perr_flag_reg <= 1'b0;
          if (!rx_in) presc_reg <= prescale;
        end
        ST_CHECK: begin
          edge_cnt_reg <= '0;
          bit_cnt_reg  <= '0;
        end
        default: begin
          edge_cnt_reg <= edge_last ? '0 : edge_cnt_reg + PRESCALE_W'(1);
        end
      endcase

      if (edge_last) begin
        case (state_reg)
          ST_DATA: begin
            shift_reg   <= {maj_bit, shift_reg[DATA_WIDTH-1:1]};
            bit_cnt_reg <= bit_cnt_reg + BCW'(1);
          end
          ST_PARITY: begin
            if (par_mismatch) begin
              perr_flag_reg <= 1'b1;
              par_err       <= 1'b1;
            end
          end
          ST_STOP: begin
            // The result is registered here so that it is visible during the
            // CHECK cycle, one clock after the stop-bit decision.
            if (!maj_bit) begin
              stp_err <= 1'b1;
            end else if (!perr_flag_reg) begin
              p_data     <= shift_reg;
              data_valid <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl with hand-computed expected values.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_in = 1'b1;
  logic [5:0] prescale = 6'd8;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  int n_checks = 0;
  int n_fail = 0;
  int n_valid = 0;
  int n_par = 0;
  int n_stp = 0;
  logic [7:0] last_data = 8'h00;
  int b_valid, b_par, b_stp;

  uart_rx_ctrl #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .prescale  (prescale),
    .par_en    (par_en),
    .par_typ   (par_typ),
    .p_data    (p_data),
    .data_valid(data_valid),
    .par_err   (par_err),
    .stp_err   (stp_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (data_valid) begin
      n_valid   <= n_valid + 1;
      last_data <= p_data;
    end
    if (par_err) n_par <= n_par + 1;
    if (stp_err) n_stp <= n_stp + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic snap();
    b_valid = n_valid;
    b_par   = n_par;
    b_stp   = n_stp;
  endtask

  // Called at a negedge; drives one sample per clock and returns at the negedge
  // following the last stop-bit sample. gbit/gk invert one sample (gbit<0: none).
  task automatic send_frame(input logic [7:0] d, input int p, input logic pen,
                            input logic pbit, input logic sbit, input int gbit, input int gk);
    int   nbits;
    logic val;
    prescale = 6'(p);
    par_en   = pen;
    nbits    = pen ? 11 : 10;
    for (int b = 0; b < nbits; b++) begin
      if (b == 0)                 val = 1'b0;
      else if (b <= 8)            val = d[b-1];
      else if (pen && b == 9)     val = pbit;
      else                        val = sbit;
      for (int k = 0; k < p; k++) begin
        rx_in = (b == gbit && k == gk) ? ~val : val;
        @(negedge clk);
      end
    end
    rx_in = 1'b1;
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_p_data", p_data, 0);
    check("rst_valid", data_valid, 0);
    check("rst_par_err", par_err, 0);
    check("rst_stp_err", stp_err, 0);
    rst = 1'b1;
    idle(4);

    // T1: P=8, no parity, 0xA5
    snap();
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, -1, 0);
    check("t1_latency_valid", data_valid, 1);
    check("t1_latency_data", p_data, 8'hA5);
    idle(6);
    check("t1_valid_cnt", n_valid - b_valid, 1);
    check("t1_p_data", last_data, 8'hA5);
    check("t1_par_cnt", n_par - b_par, 0);
    check("t1_stp_cnt", n_stp - b_stp, 0);
    check("t1_hold", p_data, 8'hA5);

    // T2: P=16, even parity, 0x3C (four ones -> parity bit 0)
    par_typ = 1'b0;
    snap();
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, -1, 0);
    idle(6);
    check("t2_valid_cnt", n_valid - b_valid, 1);
    check("t2_p_data", last_data, 8'h3C);
    check("t2_par_cnt", n_par - b_par, 0);
    snap();
    send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1, -1, 0);
    idle(6);
    check("t2b_par_cnt", n_par - b_par, 1);
    check("t2b_valid_cnt", n_valid - b_valid, 0);
    check("t2b_p_data_held", p_data, 8'h3C);

    // T3: P=32, odd parity, 0x01 (one one -> parity bit 0), stop bit 0
    par_typ = 1'b1;
    snap();
    send_frame(8'h01, 32, 1'b1, 1'b0, 1'b0, -1, 0);
    idle(8);
    check("t3_stp_cnt", n_stp - b_stp, 1);
    check("t3_par_cnt", n_par - b_par, 0);
    check("t3_valid_cnt", n_valid - b_valid, 0);
    check("t3_p_data_held", p_data, 8'h3C);

    // T4: 3-clock start glitch at P=16, then 0x55
    prescale = 6'd16;
    par_en   = 1'b0;
    snap();
    rx_in = 1'b0;
    repeat (3) @(negedge clk);
    idle(24);
    check("t4_glitch_valid", n_valid - b_valid, 0);
    check("t4_glitch_errs", (n_par - b_par) + (n_stp - b_stp), 0);
    send_frame(8'h55, 16, 1'b0, 1'b0, 1'b1, -1, 0);
    idle(6);
    check("t4_valid_cnt", n_valid - b_valid, 1);
    check("t4_p_data", last_data, 8'h55);

    // T5: centre-sample glitch on data bit 0 of 0xF0
    snap();
    send_frame(8'hF0, 16, 1'b0, 1'b0, 1'b1, 1, 8);
    idle(6);
    check("t5_valid_cnt", n_valid - b_valid, 1);
    check("t5_p_data", last_data, 8'hF0);

    // T6: back-to-back 0x12, 0x34 at P=8, then reset in a third frame
    snap();
    send_frame(8'h12, 8, 1'b0, 1'b0, 1'b1, -1, 0);
    send_frame(8'h34, 8, 1'b0, 1'b0, 1'b1, -1, 0);
    rx_in = 1'b0;
    repeat (20) @(negedge clk);
    check("t6_valid_cnt", n_valid - b_valid, 2);
    check("t6_last_data", last_data, 8'h34);
    rst = 1'b0;
    #1;
    check("t6_rst_p_data", p_data, 0);
    check("t6_rst_valid", data_valid, 0);
    check("t6_rst_errs", {par_err, stp_err}, 0);
    @(negedge clk);
    snap();
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idle(20);
    check("t6_post_rst_pulses", (n_valid - b_valid) + (n_par - b_par) + (n_stp - b_stp), 0);
    send_frame(8'h77, 8, 1'b0, 1'b0, 1'b1, -1, 0);
    idle(6);
    check("t6_77_valid_cnt", n_valid - b_valid, 1);
    check("t6_77_p_data", last_data, 8'h77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- UART receive controller: the receive-side counterpart of the transmit FSM in the UART-ALU system.
- Oversamples rx_in with a selectable prescale and majority-votes each bit.
- Deserialises LSB-first data, checks optional parity and the stop bit.
- Presents a received byte with a one-cycle valid pulse to the system controller, which feeds the ALU/register file.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.
- PRESCALE_W, 6, width of the prescale input.

Ports:
- clk  in  1  oversampling clock (prescale × baud rate).
- rst  in  1  asynchronous, active-low reset.
- rx_in  in  1  serial line; idles high.
- prescale  in  PRESCALE_W  oversampling ratio; legal values 8, 16, 32.
- par_en  in  1  1 = a parity bit follows the data bits.
- par_typ  in  1  0 = even parity, 1 = odd parity.
- p_data  out  DATA_WIDTH  last good received byte; holds its value between frames.
- data_valid  out  1  one-cycle pulse; p_data is valid in the same cycle.
- par_err  out  1  one-cycle pulse on parity mismatch.
- stp_err  out  1  one-cycle pulse when the stop bit samples 0.

Behaviour:
- Reset (asynchronous, active-low): state IDLE, all counters 0, p_data = 0, data_valid = par_err = stp_err = 0, shift register 0.
- Edge counter runs 0..P-1, where P is the prescale latched on leaving IDLE.
  - Wraps to 0 at P-1 and increments the bit counter.
  - A prescale change mid-frame has no effect until the next frame.
- Sampling: rx_in is captured at edge counts P/2-1, P/2, P/2+1. The bit value is the 2-of-3 majority, available from edge count P/2+2 onward.
- States and transitions:
  - IDLE: counters held at 0. rx_in == 0 → START; edge counter starts at 1 in the next cycle, since the detect cycle counts as edge 0.
  - START: at edge P-1, majority 0 → DATA; majority 1 (glitch) → IDLE with no error flagged.
  - DATA: at each edge P-1, shift the majority in LSB-first. After DATA_WIDTH bits → PARITY if par_en, else STOP.
  - PARITY: at edge P-1, compute the expected parity as XOR of the data bits, inverted when par_typ = 1. On mismatch, set an internal error flag and assert par_err for one cycle. Go to STOP in either case.
  - STOP: at edge P-1, majority 0 → assert stp_err for one cycle. Then → CHECK.
  - CHECK (one cycle): if neither error occurred, load p_data from the shift register and assert data_valid. Always → IDLE.
- Latency: data_valid rises exactly one clk after the final stop-bit edge (edge P-1 of the stop bit).
- A frame with any error never asserts data_valid, and p_data keeps its previous value.
- rx_in low in the CHECK cycle: not detected as a start. Start detection resumes in IDLE the following cycle, so back-to-back frames at one stop bit are still received because the stop-bit decision occurs at edge P-1.
- Reset asserted mid-frame: immediate return to IDLE, partial frame discarded, no pulses.
- Outputs are registered. The error pulses are mutually exclusive in time: par_err fires at the parity-bit end, stp_err at the stop-bit end.

Decomposition:
- Shared package: state encodings (IDLE, START, DATA, PARITY, STOP, CHECK as 3-bit constants) and legal prescale values. These are shared with the TX FSM package file.
- Sub-module: uart_rx_sampler, which takes rx_in, edge_cnt and prescale and outputs a registered majority bit. The edge/bit counters stay in the top module.

Test Plan:
- prescale = 8, par_en = 0, frame 0xA5 → p_data = 0xA5; one data_valid pulse 1 clk after stop edge 7; par_err = stp_err = 0 throughout.
- prescale = 16, par_en = 1, par_typ = 0, byte 0x3C with correct even parity bit 0 → data_valid with p_data = 0x3C; repeat with parity bit 1 → par_err pulse, no data_valid, p_data still 0x3C.
- prescale = 32, par_typ = 1, byte 0x01 with stop bit forced 0 → stp_err one-cycle pulse, no data_valid.
- rx_in low for 3 clks (prescale = 16), then high → back to IDLE with no pulses; a following valid frame 0x55 is received correctly.
- Single-cycle glitch on a data-bit centre sample (one of three samples) with byte 0xF0 → majority vote yields 0xF0, data_valid asserted.
- Two back-to-back frames 0x12, 0x34 (prescale = 8, one stop bit), then reset asserted mid-way through a third frame → two data_valid pulses; after reset all outputs 0 and the next clean frame 0x77 is received.
